// File: rtl/note_judge_if.sv
// Lane interface for note_judge_unit.
// Inputs:  i_note_start (note spawn pulse), i_btn (raw async button level).
// Outputs: o_judge (00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT), o_judge_vld (new-judgment pulse),
//          o_busy (note in flight), o_combo (consecutive non-MISS count).
// master: the lane driver / display side; slave: the judge unit.
interface note_judge_if;
  logic       i_note_start;
  logic       i_btn;
  logic [1:0] o_judge;
  logic       o_judge_vld;
  logic       o_busy;
  logic [7:0] o_combo;

  modport master (
    output i_note_start, i_btn,
    input  o_judge, o_judge_vld, o_busy, o_combo
  );

  modport slave (
    input  i_note_start, i_btn,
    output o_judge, o_judge_vld, o_busy, o_combo
  );
endinterface

// File: rtl/note_judge_unit.sv
// Timing judge for one rhythm-game lane: tracks one note from spawn, grades the
// player's press against the target arrival, holds the result for display and
// keeps a combo count.
// Ports: i_clk (rising-edge clock), i_rst_n (async active-low reset),
//        bus (note_judge_if.slave: note start/button in, judgment/busy/combo out).
module note_judge_unit #(
  parameter int unsigned TARGET      = 100,
  parameter int unsigned PERFECT_WIN = 4,
  parameter int unsigned NORMAL_WIN  = 12,
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned EARLY_MISS  = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  note_judge_if.slave  bus
);

  localparam int unsigned COMBO_W = 8;

  // Window bounds on cnt; PERFECT_WIN <= NORMAL_WIN < TARGET keeps the low bounds positive.
  localparam logic [CNT_W-1:0] PERF_LO  = CNT_W'(TARGET - PERFECT_WIN);
  localparam logic [CNT_W-1:0] PERF_HI  = CNT_W'(TARGET + PERFECT_WIN);
  localparam logic [CNT_W-1:0] NORM_LO  = CNT_W'(TARGET - NORMAL_WIN);
  localparam logic [CNT_W-1:0] NORM_HI  = CNT_W'(TARGET + NORMAL_WIN);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    J_IDLE    = 2'b00,
    J_MISS    = 2'b01,
    J_NORMAL  = 2'b10,
    J_PERFECT = 2'b11
  } judge_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     hold;
  logic                 btn_meta;
  logic                 btn_sync;
  logic                 btn_prev;
  judge_t               judge_q;
  logic                 vld_q;
  logic                 busy_q;
  logic [COMBO_W-1:0]   combo_q;

  logic                 press;
  logic                 issue;
  judge_t               code;

  // One-cycle pulse on a synchronized rising edge of the button.
  assign press = btn_sync & ~btn_prev;

  // Judgment decode; a press outranks the timeout, and any judgment outranks the
  // forced MISS of a note displaced by a new spawn.
  always_comb begin
    issue = 1'b0;
    code  = J_MISS;
    if (state == ST_ACTIVE) begin
      if (press && (cnt >= PERF_LO) && (cnt <= PERF_HI)) begin
        issue = 1'b1;
        code  = J_PERFECT;
      end else if (press && (cnt >= NORM_LO) && (cnt <= NORM_HI)) begin
        issue = 1'b1;
        code  = J_NORMAL;
      end else if (press && (cnt < NORM_LO) && (EARLY_MISS != 0)) begin
        issue = 1'b1;
        code  = J_MISS;
      end else if (cnt == NORM_HI) begin
        issue = 1'b1;
        code  = J_MISS;
      end else if (bus.i_note_start) begin
        issue = 1'b1;
        code  = J_MISS;
      end
    end
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hold     <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
      judge_q  <= J_IDLE;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      combo_q  <= '0;
    end else begin
      btn_meta <= bus.i_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;

      // A spawn always (re)starts tracking, even on the edge the old note is judged.
      if (bus.i_note_start) begin
        state  <= ST_ACTIVE;
        busy_q <= 1'b1;
        cnt    <= '0;
      end else if (issue) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else if (state == ST_ACTIVE) begin
        cnt <= cnt + CNT_W'(1);
      end

      vld_q <= issue;

      if (issue) begin
        judge_q <= code;
        hold    <= HOLD_VAL;
        if (code == J_MISS) begin
          combo_q <= '0;
        end else if (combo_q != {COMBO_W{1'b1}}) begin
          combo_q <= combo_q + COMBO_W'(1);
        end
      end else if (hold != '0) begin
        hold <= hold - CNT_W'(1);
        if (hold == CNT_W'(1)) begin
          judge_q <= J_IDLE;
        end
      end
    end
  end

  assign bus.o_judge     = judge_q;
  assign bus.o_judge_vld = vld_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_combo     = combo_q;

endmodule

// File: tb/tb_note_judge_unit.sv
// Directed bench for note_judge_unit: one instance with early presses ignored and
// one with early presses judged MISS, both fed the same note/button stimulus.
module tb_note_judge_unit;

  logic clk;
  logic rst_n;
  logic note_start;
  logic btn;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_combo = 0;

  note_judge_if bus0 ();
  note_judge_if bus1 ();

  assign bus0.i_note_start = note_start;
  assign bus0.i_btn        = btn;
  assign bus1.i_note_start = note_start;
  assign bus1.i_btn        = btn;

  note_judge_unit #(.EARLY_MISS(0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  note_judge_unit #(.EARLY_MISS(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // Spawn pulse; s is the edge that samples it.
  task automatic start_note(output int s);
    note_start = 1'b1;
    tick();
    note_start = 1'b0;
    s = cyc;
  endtask

  // Raise the button so the evaluated cnt is p; returns just after the consuming edge.
  task automatic do_press(input int s, input int p);
    wait_until(s + p - 2);
    btn = 1'b1;
    wait_until(s + p + 1);
  endtask

  initial begin
    int s;
    int s2;
    int j;
    int j2;

    rst_n      = 1'b0;
    note_start = 1'b0;
    btn        = 1'b0;
    repeat (3) tick();
    check("rst_judge", bus0.o_judge, 0);
    check("rst_vld",   bus0.o_judge_vld, 0);
    check("rst_busy",  bus0.o_busy, 0);
    check("rst_combo", bus0.o_combo, 0);
    rst_n = 1'b1;
    tick();

    // PERFECT at cnt 102
    start_note(s);
    check("start_busy", bus0.o_busy, 1);
    do_press(s, 102);
    check("perf_judge", bus0.o_judge, 3);
    check("perf_vld",   bus0.o_judge_vld, 1);
    exp_combo = 1;
    check("perf_combo", bus0.o_combo, exp_combo);
    check("perf_busy",  bus0.o_busy, 0);
    tick();
    check("perf_vld_pulse", bus0.o_judge_vld, 0);
    btn = 1'b0;

    // NORMAL at cnt 89, then display hold expiry
    start_note(s);
    do_press(s, 89);
    j = cyc;
    check("norm_judge", bus0.o_judge, 2);
    check("norm_vld",   bus0.o_judge_vld, 1);
    exp_combo = 2;
    check("norm_combo", bus0.o_combo, exp_combo);
    btn = 1'b0;
    wait_until(j + 49);
    check("hold_last", bus0.o_judge, 2);
    wait_until(j + 50);
    check("hold_clear", bus0.o_judge, 0);

    // Timeout MISS
    start_note(s);
    wait_until(s + 112);
    check("to_pre_vld",  bus0.o_judge_vld, 0);
    check("to_pre_busy", bus0.o_busy, 1);
    wait_until(s + 113);
    check("to_judge", bus0.o_judge, 1);
    check("to_vld",   bus0.o_judge_vld, 1);
    exp_combo = 0;
    check("to_combo", bus0.o_combo, exp_combo);
    check("to_busy",  bus0.o_busy, 0);

    // Press on the last window cycle beats the timeout
    start_note(s);
    do_press(s, 112);
    check("late_judge", bus0.o_judge, 2);
    check("late_vld",   bus0.o_judge_vld, 1);
    exp_combo = 1;
    check("late_combo", bus0.o_combo, exp_combo);
    btn = 1'b0;

    // Early press: ignored by dut0, MISS on dut1
    start_note(s);
    do_press(s, 50);
    check("early0_vld",  bus0.o_judge_vld, 0);
    check("early0_busy", bus0.o_busy, 1);
    check("early1_judge", bus1.o_judge, 1);
    check("early1_vld",   bus1.o_judge_vld, 1);
    check("early1_busy",  bus1.o_busy, 0);
    check("early1_combo", bus1.o_combo, 0);
    btn = 1'b0;
    do_press(s, 100);
    check("early0_judge", bus0.o_judge, 3);
    check("early0_vld2",  bus0.o_judge_vld, 1);
    exp_combo = 2;
    check("early0_combo", bus0.o_combo, exp_combo);
    check("early1_idle_vld",  bus1.o_judge_vld, 0);
    check("early1_hold_end",  bus1.o_judge, 0);
    btn = 1'b0;

    // Overlapping spawn forces MISS, new note judged from its own start
    start_note(s);
    wait_until(s + 39);
    note_start = 1'b1;
    tick();
    note_start = 1'b0;
    s2 = cyc;
    check("ovl_judge", bus0.o_judge, 1);
    check("ovl_vld",   bus0.o_judge_vld, 1);
    check("ovl_busy",  bus0.o_busy, 1);
    exp_combo = 0;
    check("ovl_combo", bus0.o_combo, exp_combo);
    do_press(s2, 101);
    j = cyc;
    check("ovl_perf", bus0.o_judge, 3);
    exp_combo = 1;
    check("ovl_combo2", bus0.o_combo, exp_combo);
    check("ovl1_combo2", bus1.o_combo, 1);
    btn = 1'b0;

    // New judgment 10 cycles into a hold restarts the hold
    start_note(s);
    wait_until(j + 9);
    note_start = 1'b1;
    tick();
    note_start = 1'b0;
    j2 = cyc;
    check("rej_judge", bus0.o_judge, 1);
    check("rej_vld",   bus0.o_judge_vld, 1);
    exp_combo = 0;
    check("rej_combo", bus0.o_combo, exp_combo);
    wait_until(j2 + 49);
    check("rej_hold",  bus0.o_judge, 1);
    check("rej_busy",  bus0.o_busy, 1);
    wait_until(j2 + 50);
    check("rej_clear", bus0.o_judge, 0);
    wait_until(j2 + 113);
    check("rej_to_judge", bus0.o_judge, 1);
    check("rej_to_vld",   bus0.o_judge_vld, 1);

    // Combo saturation
    for (int i = 0; i < 260; i++) begin
      start_note(s);
      do_press(s, 100);
      exp_combo = (exp_combo == 255) ? 255 : exp_combo + 1;
      check("sat_combo", bus0.o_combo, exp_combo);
      btn = 1'b0;
    end
    check("sat_final", bus0.o_combo, 255);
    start_note(s);
    wait_until(s + 113);
    exp_combo = 0;
    check("sat_miss_combo", bus0.o_combo, exp_combo);
    check("sat_miss_judge", bus0.o_judge, 1);

    // Button held across two notes counts once
    start_note(s);
    do_press(s, 100);
    check("held_judge1", bus0.o_judge, 3);
    check("held_vld1",   bus0.o_judge_vld, 1);
    exp_combo = 1;
    check("held_combo1", bus0.o_combo, exp_combo);
    start_note(s);
    wait_until(s + 112);
    check("held_no_vld", bus0.o_judge_vld, 0);
    check("held_busy",   bus0.o_busy, 1);
    wait_until(s + 113);
    check("held_miss", bus0.o_judge, 1);
    exp_combo = 0;
    check("held_combo2", bus0.o_combo, exp_combo);
    btn = 1'b0;

    // Asynchronous reset mid-note and mid-hold
    start_note(s);
    do_press(s, 100);
    btn = 1'b0;
    start_note(s);
    repeat (3) tick();
    check("pre_rst_busy",  bus0.o_busy, 1);
    check("pre_rst_judge", bus0.o_judge, 3);
    check("pre_rst_combo", bus0.o_combo, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_judge", bus0.o_judge, 0);
    check("arst_vld",   bus0.o_judge_vld, 0);
    check("arst_busy",  bus0.o_busy, 0);
    check("arst_combo", bus0.o_combo, 0);
    tick();
    tick();
    rst_n = 1'b1;
    btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_vld", bus0.o_judge_vld, 0);
    end
    check("post_rst_judge", bus0.o_judge, 0);
    check("post_rst_busy",  bus0.o_busy, 0);
    btn = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
